uart_cmd_parser: RTL and testbench
==================================

Name: uart_cmd_parser

Overview:
- Sits directly downstream of the UART receiver and consumes its received-byte output: data byte, data-ready level, and the data-ready clear.
- Assembles serial bytes into checksummed command frames and buffers the write payload.
- Issues one I2C transaction request per valid frame to the I2C master via valid/ready, then streams the payload bytes to it.
- Frame format: SOF, CMD{rw, addr[6:0]}, LEN, payload[LEN] (writes only), CHK = XOR of CMD, LEN and all payload bytes.

Parameters:
- MAX_LEN, 16: payload buffer depth in bytes, range 1..255.
- SOF_BYTE, 8'hA5: start-of-frame marker.
- TIMEOUT_CYCLES, 4096: inter-byte idle limit in clk cycles (optional feature only).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- rx_data  in  8  received byte from the UART receiver.
- rx_data_ready  in  1  level, high while rx_data is unconsumed.
- rx_data_ack  out  1  one-cycle pulse; drives the receiver's data-ready clear input.
- cmd_valid  out  1  transaction request valid.
- cmd_ready  in  1  I2C master accepts the request.
- cmd_rw  out  1  1 = read, 0 = write (CMD bit 7).
- cmd_addr  out  7  I2C slave address (CMD bits 6:0).
- cmd_len  out  8  byte count.
- wr_valid  out  1  payload byte valid.
- wr_ready  in  1  I2C master takes the payload byte.
- wr_data  out  8  payload byte.
- busy  out  1  high in any state except S_SOF.
- err_chk  out  1  one-cycle pulse on checksum mismatch.
- err_len  out  1  one-cycle pulse when LEN is 0 or LEN > MAX_LEN.

Behaviour:
- Reset: asynchronous, active-low. All outputs 0, state S_SOF, checksum accumulator 0, buffer pointers 0. Buffer contents are don't-care.
- Byte accept rule:
  - A byte is accepted at a clk edge when rx_data_ready=1, rx_data_ack=0, and the state is one of S_SOF, S_CMD, S_LEN, S_PAY, S_CHK.
  - rx_data_ack is registered: high exactly the following cycle.
  - The ack=1 cycle blocks re-accepting the same still-high ready, so each byte is acked exactly once.
  - In S_ISSUE and S_STREAM no byte is accepted and no ack is given; the byte stays pending in the receiver.
- States:
  - S_SOF: accepted byte == SOF_BYTE -> S_CMD, clear checksum. Any other byte is acked and discarded.
  - S_CMD: latch rw/addr, chk ^= byte -> S_LEN.
  - S_LEN:
    - If byte is 0 or > MAX_LEN: pulse err_len -> S_SOF.
    - Otherwise latch len, chk ^= byte.
    - Write -> S_PAY with write pointer 0; read -> S_CHK.
  - S_PAY: store byte at wptr, chk ^= byte, wptr++. After the LEN-th byte -> S_CHK.
  - S_CHK: byte == chk -> S_ISSUE; else pulse err_chk -> S_SOF. Buffer is discarded either way on error.
  - S_ISSUE:
    - cmd_valid=1 with cmd_rw/addr/len stable until the cmd_valid & cmd_ready edge.
    - Then write -> S_STREAM with rptr 0; read -> S_SOF.
  - S_STREAM:
    - wr_valid=1, wr_data=buf[rptr] (registered output, stable while wr_valid & !wr_ready).
    - rptr++ on each wr_valid & wr_ready.
    - After the LEN-th transfer, wr_valid drops the next cycle -> S_SOF.
- Latency: cmd_valid rises on the cycle after the CHK byte is accepted.
- Boundaries:
  - LEN == MAX_LEN fills the buffer exactly; no wrap.
  - A SOF_BYTE value inside CMD, LEN or payload is treated as data, not resync.
  - cmd_ready held high while idle has no effect.
  - If the receiver overruns during S_ISSUE/S_STREAM, the byte is lost. This is a host protocol rule: the host waits for completion before sending the next frame.
- Reset mid-frame or mid-stream: immediate return to the reset state; no partial outputs.

Optional Feature:
- UART_CMD_TIMEOUT_EN defined:
  - A 16-bit counter clears on every accepted byte and counts clk cycles while in S_CMD, S_LEN, S_PAY or S_CHK.
  - When the count reaches TIMEOUT_CYCLES: pulse err_chk, go to S_SOF, clear the counter.
  - The counter is idle in S_SOF, S_ISSUE and S_STREAM.
- Undefined: no counter; a partial frame waits indefinitely.

Decomposition:
- Package uart_cmd_pkg:
  - state enum (S_SOF, S_CMD, S_LEN, S_PAY, S_CHK, S_ISSUE, S_STREAM);
  - default SOF constant 8'hA5;
  - CMD field bit positions (RW bit 7, address bits 6:0).
- Sub-module uart_cmd_buf:
  - MAX_LEN x 8 register buffer;
  - write port (we, wptr, wdata);
  - registered read port (rptr, rdata);
  - pointer width $clog2(MAX_LEN).

Test Plan:
- Write frame A5 50 03 11 22 33 chk=50^03^11^22^33=53 -> cmd_valid, rw=0, addr=7'h50, len=3; then wr_data 11, 22, 33; one ack per input byte.
- Read frame A5 D0 02 chk=D2 -> cmd_rw=1, addr=7'h50, len=2; no wr_valid.
- Same write frame with chk=00 -> err_chk single pulse, no cmd_valid, back to S_SOF; next good frame accepted.
- LEN=00, then LEN=17 with MAX_LEN=16 -> err_len pulse each time; following bytes discarded until A5.
- Hold cmd_ready=0 for 50 cycles, then toggle wr_ready 1/0 -> request fields stable while held; each payload byte presented until taken; no duplicates or drops.
- With UART_CMD_TIMEOUT_EN: A5 50 then silence for 4096 cycles -> err_chk pulse, state S_SOF; reset_n low mid-S_STREAM -> all outputs 0 immediately.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared state encoding, default SOF marker and CMD field positions for the
// UART command-frame parser.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        S_SOF,
        S_CMD,
        S_LEN,
        S_PAY,
        S_CHK,
        S_ISSUE,
        S_STREAM
    } state_t;

    localparam logic [7:0] SOF_DEFAULT  = 8'hA5;
    localparam int         CMD_RW_BIT   = 7;
    localparam int         CMD_ADDR_MSB = 6;

    // A one-entry buffer still needs a 1-bit pointer.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/uart_cmd_buf.sv
// Payload buffer: MAX_LEN x 8 registers with one write port and a registered
// read port.
module uart_cmd_buf
    import uart_cmd_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int PTR_W   = ptr_width(MAX_LEN)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             we,
    input  logic [PTR_W-1:0] wptr,
    input  logic [7:0]       wdata,
    input  logic [PTR_W-1:0] rptr,
    output logic [7:0]       rdata
);

    logic [7:0] mem [MAX_LEN];

    // NOTE: the storage array has no reset; an entry is only read after the
    // current frame has written it, so resetting it would buy nothing.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata <= '0;
        end else begin
            rdata <= mem[rptr];
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// Turns UART bytes into checksummed I2C command frames and streams the write
// payload. Define UART_CMD_TIMEOUT_EN to abort frames after an inter-byte idle limit.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int         MAX_LEN  = 16,
    parameter logic [7:0] SOF_BYTE = SOF_DEFAULT
`ifdef UART_CMD_TIMEOUT_EN
    ,
    parameter int         TIMEOUT_CYCLES = 4096
`endif
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] rx_data,
    input  logic       rx_data_ready,
    output logic       rx_data_ack,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic       cmd_rw,
    output logic [6:0] cmd_addr,
    output logic [7:0] cmd_len,
    output logic       wr_valid,
    input  logic       wr_ready,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic       err_chk,
    output logic       err_len
);

    localparam int         PTR_W     = ptr_width(MAX_LEN);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t           state;
    logic [7:0]       chk;
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [PTR_W-1:0] rptr_next;
    logic             accept;
    logic             wr_fire;
`ifdef UART_CMD_TIMEOUT_EN
    logic [15:0]      tmo_cnt;
`endif

    // The ack cycle masks the still-high ready so each byte is taken once.
    assign accept    = rx_data_ready && !rx_data_ack &&
                       (state inside {S_SOF, S_CMD, S_LEN, S_PAY, S_CHK});
    assign wr_fire   = wr_valid && wr_ready;
    assign busy      = (state != S_SOF);

    // The buffer reads ahead with the post-transfer pointer so wr_data already
    // holds the next byte on the cycle after a handshake.
    assign rptr_next = wr_fire ? rptr + 1'b1 : rptr;

    uart_cmd_buf #(
        .MAX_LEN (MAX_LEN),
        .PTR_W   (PTR_W)
    ) u_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (accept && (state == S_PAY)),
        .wptr    (wptr),
        .wdata   (rx_data),
        .rptr    (rptr_next),
        .rdata   (wr_data)
    );

    // NOTE: sequential state is written with non-blocking assignments so every
    // branch below sees the pre-edge values of state, chk and the pointers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_SOF;
            chk         <= '0;
            wptr        <= '0;
            rptr        <= '0;
            rx_data_ack <= 1'b0;
            cmd_valid   <= 1'b0;
            cmd_rw      <= 1'b0;
            cmd_addr    <= '0;
            cmd_len     <= '0;
            wr_valid    <= 1'b0;
            err_chk     <= 1'b0;
            err_len     <= 1'b0;
`ifdef UART_CMD_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
        end else begin
            rx_data_ack <= accept;
            err_chk     <= 1'b0;
            err_len     <= 1'b0;
            rptr        <= rptr_next;

            case (state)
                S_SOF: begin
                    if (accept && (rx_data == SOF_BYTE)) begin
                        chk   <= '0;
                        state <= S_CMD;
                    end
                end
                S_CMD: begin
                    if (accept) begin
                        cmd_rw   <= rx_data[CMD_RW_BIT];
                        cmd_addr <= rx_data[CMD_ADDR_MSB:0];
                        chk      <= chk ^ rx_data;
                        state    <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (accept) begin
                        if ((rx_data == 8'd0) || (rx_data > MAX_LEN_B)) begin
                            err_len <= 1'b1;
                            state   <= S_SOF;
                        end else begin
                            cmd_len <= rx_data;
                            chk     <= chk ^ rx_data;
                            wptr    <= '0;
                            state   <= cmd_rw ? S_CHK : S_PAY;
                        end
                    end
                end
                S_PAY: begin
                    if (accept) begin
                        chk  <= chk ^ rx_data;
                        wptr <= wptr + 1'b1;
                        if (8'(wptr) == cmd_len - 8'd1) begin
                            state <= S_CHK;
                        end
                    end
                end
                S_CHK: begin
                    if (accept) begin
                        if (rx_data == chk) begin
                            cmd_valid <= 1'b1;
                            rptr      <= '0;
                            state     <= S_ISSUE;
                        end else begin
                            err_chk <= 1'b1;
                            state   <= S_SOF;
                        end
                    end
                end
                S_ISSUE: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        if (cmd_rw) begin
                            state <= S_SOF;
                        end else begin
                            wr_valid <= 1'b1;
                            state    <= S_STREAM;
                        end
                    end
                end
                S_STREAM: begin
                    if (wr_fire && (8'(rptr) == cmd_len - 8'd1)) begin
                        wr_valid <= 1'b0;
                        state    <= S_SOF;
                    end
                end
                default: state <= S_SOF;
            endcase

`ifdef UART_CMD_TIMEOUT_EN
            // Only a partially received frame can time out.
            if (accept || !(state inside {S_CMD, S_LEN, S_PAY, S_CHK})) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                tmo_cnt <= '0;
                err_chk <= 1'b1;
                state   <= S_SOF;
            end else begin
                tmo_cnt <= tmo_cnt + 16'd1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Randomized self-checking bench for uart_cmd_parser; expectations come from a
// frame-level model of the protocol kept in queues.
module tb_uart_cmd_parser;

    localparam int         MAX_LEN  = 16;
    localparam logic [7:0] SOF      = 8'hA5;
    localparam int         N_RANDOM = 40;

    typedef enum int {F_GOOD, F_BAD_CHK, F_BAD_LEN} frame_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_data_ready = 1'b0;
    logic       rx_data_ack;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rw;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_len;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_data;
    logic       busy;
    logic       err_chk;
    logic       err_len;

    int checks = 0;
    int errors = 0;
    int sink_mode = 0;

    logic [15:0] exp_cmd[$];
    logic [15:0] got_cmd[$];
    logic [7:0]  exp_wr[$];
    logic [7:0]  got_wr[$];
    int exp_err_chk = 0, got_err_chk = 0;
    int exp_err_len = 0, got_err_len = 0;
    int exp_acks = 0, got_acks = 0;

    logic        prev_cmd_stall = 1'b0, prev_wr_stall = 1'b0;
    logic        prev_ack = 1'b0, prev_echk = 1'b0, prev_elen = 1'b0;
    logic [15:0] prev_fields = '0;
    logic [7:0]  prev_data = '0;

    always #5 clk = ~clk;

    uart_cmd_parser #(.MAX_LEN(MAX_LEN)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .rx_data       (rx_data),
        .rx_data_ready (rx_data_ready),
        .rx_data_ack   (rx_data_ack),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_rw        (cmd_rw),
        .cmd_addr      (cmd_addr),
        .cmd_len       (cmd_len),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_data       (wr_data),
        .busy          (busy),
        .err_chk       (err_chk),
        .err_len       (err_len)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // I2C-master side: 0 random, 1 stalled, 2 toggling, 3 accept cmd but stall data.
    initial begin
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (sink_mode)
                0: begin
                    cmd_ready = 1'($urandom & 1);
                    wr_ready  = 1'($urandom & 1);
                end
                1: begin
                    cmd_ready = 1'b0;
                    wr_ready  = 1'b0;
                end
                2: begin
                    cmd_ready = ~cmd_ready;
                    wr_ready  = ~wr_ready;
                end
                default: begin
                    cmd_ready = 1'b1;
                    wr_ready  = 1'b0;
                end
            endcase
        end
    end

    // Monitor: records handshakes and pulses, checks hold rules under stall.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_cmd_stall = 1'b0;
                prev_wr_stall  = 1'b0;
                prev_ack       = 1'b0;
                prev_echk      = 1'b0;
                prev_elen      = 1'b0;
            end else begin
                if (prev_cmd_stall) begin
                    check("cmd_hold_valid", cmd_valid, 1);
                    check("cmd_hold_fields", {cmd_rw, cmd_addr, cmd_len}, prev_fields);
                end
                if (prev_wr_stall) begin
                    check("wr_hold_valid", wr_valid, 1);
                    check("wr_hold_data", wr_data, prev_data);
                end
                if (cmd_valid && cmd_ready) got_cmd.push_back({cmd_rw, cmd_addr, cmd_len});
                if (wr_valid && wr_ready) got_wr.push_back(wr_data);
                if (rx_data_ack) begin
                    got_acks++;
                    check("ack_single_cycle", prev_ack, 0);
                end
                if (err_chk) begin
                    got_err_chk++;
                    check("err_chk_single_cycle", prev_echk, 0);
                end
                if (err_len) begin
                    got_err_len++;
                    check("err_len_single_cycle", prev_elen, 0);
                end
                prev_cmd_stall = cmd_valid && !cmd_ready;
                prev_wr_stall  = wr_valid && !wr_ready;
                prev_fields    = {cmd_rw, cmd_addr, cmd_len};
                prev_data      = wr_data;
                prev_ack       = rx_data_ack;
                prev_echk      = err_chk;
                prev_elen      = err_len;
            end
        end
    end

    // UART receiver side: hold the byte with ready high until it is acked.
    task automatic send_byte(input logic [7:0] b);
        bit acked = 1'b0;
        @(negedge clk);
        rx_data       = b;
        rx_data_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rx_data_ack) begin
                acked = 1'b1;
                break;
            end
        end
        rx_data_ready = 1'b0;
        exp_acks++;
        check("ack_seen", acked, 1);
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy) begin
                idle = 1'b1;
                break;
            end
        end
        check("idle_reached", idle, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic compare();
        check("cmd_count", got_cmd.size(), exp_cmd.size());
        while (got_cmd.size() > 0 && exp_cmd.size() > 0)
            check("cmd_fields", got_cmd.pop_front(), exp_cmd.pop_front());
        check("wr_count", got_wr.size(), exp_wr.size());
        while (got_wr.size() > 0 && exp_wr.size() > 0)
            check("wr_byte", got_wr.pop_front(), exp_wr.pop_front());
        got_cmd.delete();
        exp_cmd.delete();
        got_wr.delete();
        exp_wr.delete();
        check("err_chk_count", got_err_chk, exp_err_chk);
        check("err_len_count", got_err_len, exp_err_len);
        check("ack_count", got_acks, exp_acks);
    endtask

    function automatic logic [7:0] junk_byte();
        logic [7:0] b;
        do b = 8'($urandom); while (b == SOF);
        return b;
    endfunction

    // Builds one frame from the protocol rules and records what it must produce.
    task automatic send_frame(input frame_t kind, input logic rw, input int len, input bit wait_done);
        logic [7:0] bytes[$];
        logic [7:0] cmd, chk, b;
        int         n_junk = $urandom_range(0, 2);
        for (int i = 0; i < n_junk; i++) bytes.push_back(junk_byte());
        cmd = {rw, 7'($urandom)};
        bytes.push_back(SOF);
        bytes.push_back(cmd);
        bytes.push_back(8'(len));
        if (kind == F_BAD_LEN) begin
            for (int i = 0; i < n_junk; i++) bytes.push_back(junk_byte());
            exp_err_len++;
        end else begin
            chk = cmd ^ 8'(len);
            if (!rw) begin
                for (int i = 0; i < len; i++) begin
                    b = ($urandom_range(0, 3) == 0) ? SOF : 8'($urandom);
                    bytes.push_back(b);
                    chk ^= b;
                    if (kind == F_GOOD) exp_wr.push_back(b);
                end
            end
            if (kind == F_BAD_CHK) begin
                chk ^= 8'($urandom_range(1, 255));
                exp_err_chk++;
            end else begin
                exp_cmd.push_back({cmd, 8'(len)});
            end
            bytes.push_back(chk);
        end
        foreach (bytes[i]) send_byte(bytes[i]);
        check("cmd_valid_after_last_byte", cmd_valid, (kind == F_GOOD) ? 1 : 0);
        if (wait_done) begin
            wait_idle();
            compare();
        end
    endtask

    initial begin
        bit seen;
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_wr_valid", wr_valid, 0);
        check("rst_ack", rx_data_ack, 0);
        check("rst_errs", {err_chk, err_len}, 0);
        check("rst_cmd_fields", {cmd_rw, cmd_addr, cmd_len}, 0);
        check("rst_wr_data", wr_data, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Write frame with a long gap after CMD: frame must wait, not abort.
        send_byte(8'hA5);
        send_byte(8'h50);
        repeat (300) @(negedge clk);
        check("partial_frame_waits", busy, 1);
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h53);
        check("cmd_latency", cmd_valid, 1);
        exp_cmd.push_back({1'b0, 7'h50, 8'd3});
        exp_wr.push_back(8'h11);
        exp_wr.push_back(8'h22);
        exp_wr.push_back(8'h33);
        wait_idle();
        compare();

        // Read frame: request only, no payload stream.
        send_byte(8'hA5);
        send_byte(8'hD0);
        send_byte(8'h02);
        send_byte(8'hD2);
        exp_cmd.push_back({1'b1, 7'h50, 8'd2});
        wait_idle();
        compare();

        // Bad checksum.
        send_byte(8'hA5);
        send_byte(8'h50);
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h00);
        exp_err_chk++;
        check("bad_chk_idle", busy, 0);
        wait_idle();
        compare();

        // LEN = 0 and LEN = MAX_LEN+1, followed by bytes that must be discarded.
        send_byte(8'hA5);
        send_byte(8'h50);
        send_byte(8'h00);
        send_byte(8'h50);
        send_byte(8'h03);
        exp_err_len++;
        send_byte(8'hA5);
        send_byte(8'h50);
        send_byte(8'(MAX_LEN + 1));
        send_byte(8'h11);
        send_byte(8'h22);
        exp_err_len++;
        wait_idle();
        compare();

        // Buffer filled exactly.
        send_frame(F_GOOD, 1'b0, MAX_LEN, 1'b1);
        send_frame(F_GOOD, 1'b0, 1, 1'b1);

        // Request held off for 50 cycles, then toggling ready on both ports.
        sink_mode = 1;
        send_frame(F_GOOD, 1'b0, 4, 1'b0);
        repeat (50) @(negedge clk);
        check("cmd_held_50", cmd_valid, 1);
        check("no_wr_before_cmd", wr_valid, 0);
        sink_mode = 2;
        wait_idle();
        compare();

        // Reset while the payload stream is stalled.
        sink_mode = 3;
        send_frame(F_GOOD, 1'b0, 5, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (wr_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("stream_reached", seen, 1);
        reset_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_valids", {cmd_valid, wr_valid}, 0);
        check("midrst_cmd_fields", {cmd_rw, cmd_addr, cmd_len}, 0);
        check("midrst_wr_data", wr_data, 0);
        check("midrst_ack_errs", {rx_data_ack, err_chk, err_len}, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        got_cmd.delete();
        exp_cmd.delete();
        got_wr.delete();
        exp_wr.delete();
        sink_mode = 0;
        send_frame(F_GOOD, 1'b0, 3, 1'b1);

`ifdef UART_CMD_TIMEOUT_EN
        send_byte(8'hA5);
        send_byte(8'h50);
        repeat (4100) @(negedge clk);
        exp_err_chk++;
        check("timeout_to_idle", busy, 0);
        compare();
`endif

        for (int n = 0; n < N_RANDOM; n++) begin
            int sel = $urandom_range(0, 9);
            if (sel < 4)
                send_frame(F_GOOD, 1'b0, $urandom_range(1, MAX_LEN), 1'b1);
            else if (sel < 6)
                send_frame(F_GOOD, 1'b1, $urandom_range(1, MAX_LEN), 1'b1);
            else if (sel < 8)
                send_frame(F_BAD_CHK, 1'($urandom & 1), $urandom_range(1, MAX_LEN), 1'b1);
            else
                send_frame(F_BAD_LEN, 1'($urandom & 1),
                           ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAX_LEN + 1, 255), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
